bnn_img_loader: RTL and testbench
=================================

Name: bnn_img_loader

Overview:
- Producer and consumer on the host side of the BNN inference wrapper.
- Assembles a 900-bit binary image from a byte stream (SPI/UART receiver side) and drives the wrapper's img_in, img_buffer_full and bnn_enable.
- Waits for result_ready, latches the 4-bit class, hands it to the host via valid/ack, then pulses bnn_clear to re-arm the wrapper.

Parameters:
- IMG_BITS, 900, image size in bits (30x30).
- BYTE_W, 8, input byte width.
- N_BYTES, (IMG_BITS+BYTE_W-1)/BYTE_W = 113, bytes per image.
- TIMEOUT_CYCLES, 4096, maximum clk cycles in INFER before abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  pixel byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- host_clear  in  1  synchronous abort/flush.
- img_out  out  900  registered image to the wrapper.
- img_buffer_full  out  1  image complete.
- bnn_enable  out  1  start inference.
- bnn_clear  out  1  one-cycle wrapper clear.
- result_in  in  4  class from the wrapper (0-9, 10 = blank image).
- result_ready_in  in  1  wrapper result valid.
- result_out  out  4  latched result.
- result_valid  out  1  result available to the host.
- result_ack  in  1  host consumed the result.
- err  out  1  last result was timeout or checksum error.
- byte_count  out  7  bytes accepted for the current image.

Behaviour:
- Reset values:
  - state = LOAD.
  - img_out, byte_count, result_out = 0.
  - rx_ready = 1.
  - img_buffer_full, bnn_enable, bnn_clear, result_valid, err = 0.
  - timeout counter = 0.
- States: LOAD, INFER, REPORT, CLEAR.
- LOAD:
  - rx_ready = 1.
  - Byte transfer occurs when rx_valid && rx_ready.
  - Byte k bit j is written to img_out[8k+j] (LSB-first).
  - For k = 112, only bits [3:0] are stored; bits [7:4] are ignored.
  - byte_count increments per transfer.
  - On the transfer of byte N_BYTES-1: next cycle state = INFER, rx_ready = 0.
- INFER:
  - img_buffer_full = 1 and bnn_enable = 1 (registered), asserted the cycle after the last byte.
  - Timeout counter increments each cycle.
  - First cycle with result_ready_in = 1: result_out <= result_in, err <= 0, state -> REPORT.
  - Counter reaching TIMEOUT_CYCLES-1 with no result_ready_in: result_out <= 4'hF, err <= 1, state -> REPORT.
  - result_ready_in and timeout in the same cycle: the result wins.
- REPORT:
  - result_valid = 1; img_buffer_full and bnn_enable drop.
  - result_out and err are held stable.
  - On result_ack: state -> CLEAR.
  - result_ack in other states is ignored.
- CLEAR:
  - Exactly one cycle with bnn_clear = 1.
  - img_out, byte_count and timeout counter zeroed; result_valid -> 0.
  - Next state = LOAD.
  - result_out and err retain their last values until the next capture.
- host_clear, any state: next state = CLEAR, which performs the full flush.
  - A byte presented in that cycle is dropped; rx_ready = 0 during CLEAR.
  - host_clear held for multiple cycles keeps the loader in CLEAR, with bnn_clear high each cycle.
- Sampling: result_ready_in is sampled only in INFER. The wrapper's level-held ready in its DONE state is not re-captured after CLEAR, because bnn_clear resets it.
- Asynchronous reset mid-image discards the partial image.
- Inference latency is defined by the wrapper. The loader adds:
  - 1 cycle from the last byte to bnn_enable;
  - 1 cycle from result_ready_in to result_valid;
  - 1 cycle from result_ack to bnn_clear.

Optional Feature:
- Macro: BNN_IMG_CHECKSUM_EN.
- When defined:
  - LOAD accepts N_BYTES+1 bytes; the final byte is a checksum equal to the XOR of all N_BYTES image bytes (the full 8 bits of byte 112).
  - A running XOR register is cleared in CLEAR.
  - On match: proceed to INFER as normal.
  - On mismatch: skip INFER (bnn_enable is never asserted), result_out = 4'hE, err = 1, go directly to REPORT.
  - byte_count reaches 114.
- When not defined: no checksum byte, no XOR register; behaviour is exactly as above.

Test Plan:
- Reset, then stream 113 bytes of 0xFF back-to-back:
  - img_out[899:0] all 1s;
  - img_buffer_full and bnn_enable rise 1 cycle after the last byte;
  - rx_ready = 0.
- In INFER, drive result_in = 7 and result_ready_in = 1 after 50 cycles:
  - result_out = 7, result_valid = 1 next cycle, err = 0;
  - after result_ack, bnn_clear is high for exactly 1 cycle and the loader returns to LOAD with byte_count = 0.
- Byte k = k mod 256 with rx_valid toggling every other cycle:
  - img_out[8k+:8] = k for k < 112;
  - img_out[899:896] = 4'h0 (112 & 0xF);
  - byte_count counts only transfers.
- Never assert result_ready_in: after 4096 INFER cycles, result_out = 4'hF, err = 1, result_valid = 1.
- Assert host_clear after 60 bytes:
  - 1-cycle bnn_clear, img_out = 0, byte_count = 0;
  - next 113 bytes form a fresh image.
- With BNN_IMG_CHECKSUM_EN:
  - correct XOR byte leads to inference;
  - corrupted checksum gives result_out = 4'hE, err = 1, and bnn_enable is never asserted.

Source files
------------

// File: rtl/bnn_img_loader_if.sv
// ============================================================================
// Module      : bnn_img_loader_if
// Description : Byte-stream, wrapper and host-result signals of the BNN image
//               loader. The master modport is the loader side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bnn_img_loader_if #(
   parameter int IMG_BITS = 900,
   parameter int BYTE_W   = 8
);
   logic [BYTE_W-1:0]   rx_data;
   logic                rx_valid;
   logic                rx_ready;
   logic                host_clear;
   logic [IMG_BITS-1:0] img_out;
   logic                img_buffer_full;
   logic                bnn_enable;
   logic                bnn_clear;
   logic [3:0]          result_in;
   logic                result_ready_in;
   logic [3:0]          result_out;
   logic                result_valid;
   logic                result_ack;
   logic                err;
   logic [6:0]          byte_count;

   modport master (
      input  rx_data, rx_valid, host_clear, result_in, result_ready_in, result_ack,
      output rx_ready, img_out, img_buffer_full, bnn_enable, bnn_clear,
             result_out, result_valid, err, byte_count
   );

   modport slave (
      output rx_data, rx_valid, host_clear, result_in, result_ready_in, result_ack,
      input  rx_ready, img_out, img_buffer_full, bnn_enable, bnn_clear,
             result_out, result_valid, err, byte_count
   );
endinterface

`default_nettype wire

// File: rtl/bnn_img_loader.sv
// ============================================================================
// Module      : bnn_img_loader
// Description : Assembles a binary image from a byte stream, runs one BNN
//               inference and hands the class to the host via valid/ack.
//               Optional macro BNN_IMG_CHECKSUM_EN adds a trailing XOR byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_img_loader #(
   parameter int IMG_BITS       = 900,
   parameter int BYTE_W         = 8,
   parameter int N_BYTES        = (IMG_BITS + BYTE_W - 1) / BYTE_W,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   bnn_img_loader_if.master  bus
);

`ifdef BNN_IMG_CHECKSUM_EN
   localparam int N_LOAD = N_BYTES + 1;
`else
   localparam int N_LOAD = N_BYTES;
`endif
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] S_LOAD   = 2'd0;
   localparam logic [1:0] S_INFER  = 2'd1;
   localparam logic [1:0] S_REPORT = 2'd2;
   localparam logic [1:0] S_CLEAR  = 2'd3;

   logic [1:0]          r_state;
   logic [1:0]          w_next;
   logic [6:0]          r_byte_count;
   logic [TMR_W-1:0]    r_timer;
   logic [3:0]          r_result;
   logic                r_err;
   logic [IMG_BITS-1:0] w_img;
   logic                w_xfer;
   logic                w_last;
   logic                w_timeout;
   logic                w_flush;
   logic                w_infer_live;
`ifdef BNN_IMG_CHECKSUM_EN
   logic [BYTE_W-1:0]   r_xor;
   logic                w_sum_ok;
`endif

   // A byte arriving together with host_clear is dropped.
   assign w_xfer       = (r_state == S_LOAD) && bus.rx_valid && !bus.host_clear;
   assign w_last       = (r_byte_count == 7'(N_LOAD - 1));
   assign w_timeout    = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
   assign w_flush      = (r_state == S_CLEAR);
   assign w_infer_live = (r_state == S_INFER) && !bus.host_clear;
`ifdef BNN_IMG_CHECKSUM_EN
   assign w_sum_ok     = (bus.rx_data == r_xor);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD: begin
            if (w_xfer && w_last) begin
`ifdef BNN_IMG_CHECKSUM_EN
               w_next = w_sum_ok ? S_INFER : S_REPORT;
`else
               w_next = S_INFER;
`endif
            end
         end
         S_INFER: begin
            if (bus.result_ready_in || w_timeout) begin
               w_next = S_REPORT;
            end
         end
         S_REPORT: begin
            if (bus.result_ack) begin
               w_next = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_next = S_LOAD;
         end
         default: begin
            w_next = S_LOAD;
         end
      endcase
      if (bus.host_clear) begin
         w_next = S_CLEAR;
      end
   end

   always_comb begin
      bus.rx_ready        = 1'b0;
      bus.img_buffer_full = 1'b0;
      bus.bnn_enable      = 1'b0;
      bus.result_valid    = 1'b0;
      bus.bnn_clear       = 1'b0;
      case (r_state)
         S_LOAD:   bus.rx_ready = 1'b1;
         S_INFER: begin
            bus.img_buffer_full = 1'b1;
            bus.bnn_enable      = 1'b1;
         end
         S_REPORT: bus.result_valid = 1'b1;
         S_CLEAR:  bus.bnn_clear    = 1'b1;
         default:  bus.rx_ready     = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_count <= '0;
         r_timer      <= '0;
`ifdef BNN_IMG_CHECKSUM_EN
         r_xor        <= '0;
`endif
      end else if (w_flush) begin
         r_byte_count <= '0;
         r_timer      <= '0;
`ifdef BNN_IMG_CHECKSUM_EN
         r_xor        <= '0;
`endif
      end else begin
         if (w_xfer) begin
            r_byte_count <= r_byte_count + 7'd1;
`ifdef BNN_IMG_CHECKSUM_EN
            r_xor        <= r_xor ^ bus.rx_data;
`endif
         end
         if (w_infer_live) begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   // Result wins over a timeout in the same cycle; both survive CLEAR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_infer_live) begin
            if (bus.result_ready_in) begin
               r_result <= bus.result_in;
               r_err    <= 1'b0;
            end else if (w_timeout) begin
               r_result <= 4'hF;
               r_err    <= 1'b1;
            end
         end
`ifdef BNN_IMG_CHECKSUM_EN
         if (w_xfer && w_last && !w_sum_ok) begin
            r_result <= 4'hE;
            r_err    <= 1'b1;
         end
`endif
      end
   end

   // One register slice per byte; the last slice keeps only the bits that fit.
   generate
      for (genvar b = 0; b < N_BYTES; b++) begin : g_byte
         localparam int LO = b * BYTE_W;
         localparam int W  = ((IMG_BITS - LO) < BYTE_W) ? (IMG_BITS - LO) : BYTE_W;
         logic [W-1:0] r_seg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_seg <= '0;
            end else if (w_flush) begin
               r_seg <= '0;
            end else if (w_xfer && (r_byte_count == 7'(b))) begin
               r_seg <= bus.rx_data[W-1:0];
            end
         end

         assign w_img[LO +: W] = r_seg;
      end
   endgenerate

   assign bus.img_out    = w_img;
   assign bus.result_out = r_result;
   assign bus.err        = r_err;
   assign bus.byte_count = r_byte_count;

endmodule

`default_nettype wire

// File: tb/tb_bnn_img_loader.sv
// ============================================================================
// Module      : tb_bnn_img_loader
// Description : Self-checking bench for bnn_img_loader with a byte-level image
//               model; define BNN_IMG_CHECKSUM_EN to exercise the checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bnn_img_loader;
   localparam int IMG_BITS = 900;
   localparam int N_BYTES  = 113;
`ifdef BNN_IMG_CHECKSUM_EN
   localparam int N_LOAD = N_BYTES + 1;
`else
   localparam int N_LOAD = N_BYTES;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   en_cycles = 0;
   logic [7:0] img_bytes [0:N_BYTES-1];

   always #5 clk = ~clk;

   bnn_img_loader_if #(.IMG_BITS(IMG_BITS), .BYTE_W(8)) bus ();

   bnn_img_loader #(
      .IMG_BITS(IMG_BITS), .BYTE_W(8), .N_BYTES(N_BYTES), .TIMEOUT_CYCLES(4096)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(posedge clk) if (bus.bnn_enable === 1'b1) en_cycles <= en_cycles + 1;

   // Byte k bit j lands on image bit 8k+j; bits past the image are discarded.
   function automatic logic [IMG_BITS-1:0] model_img();
      logic [IMG_BITS-1:0] m;
      m = '0;
      for (int k = 0; k < N_BYTES; k++)
         for (int j = 0; j < 8; j++)
            if (k * 8 + j < IMG_BITS) m[k*8+j] = img_bytes[k][j];
      return m;
   endfunction

   function automatic logic [7:0] model_sum();
      logic [7:0] s;
      s = 8'h00;
      for (int k = 0; k < N_BYTES; k++) s = s ^ img_bytes[k];
      return s;
   endfunction

   task automatic rand_bytes();
      for (int k = 0; k < N_BYTES; k++) img_bytes[k] = 8'($urandom);
   endtask

   task automatic load_image(input int gap_max, input bit bad_sum);
      logic [7:0] cks;
      cks = model_sum() ^ (bad_sum ? 8'($urandom_range(255, 1)) : 8'h00);
      for (int k = 0; k < N_LOAD; k++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(negedge clk);
         end
         bus.rx_valid = 1'b1;
         if (k < N_BYTES) bus.rx_data = img_bytes[k];
         else             bus.rx_data = cks;
         @(negedge clk);
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic run_result(input logic [3:0] res, input int delay);
      repeat (delay) @(negedge clk);
      bus.result_in       = res;
      bus.result_ready_in = 1'b1;
      @(negedge clk);
      bus.result_ready_in = 1'b0;
      bus.result_in       = 4'($urandom);
   endtask

   task automatic do_ack(input int delay);
      repeat (delay) @(negedge clk);
      bus.result_ack = 1'b1;
      @(negedge clk);
      bus.result_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (bus.rx_ready !== 1'b1 || bus.img_buffer_full !== 1'b0 || bus.bnn_enable !== 1'b0 ||
          bus.bnn_clear !== 1'b0 || bus.result_valid !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b full=%b en=%b clr=%b val=%b err=%b want 1 0 0 0 0 0",
                  bus.rx_ready, bus.img_buffer_full, bus.bnn_enable, bus.bnn_clear,
                  bus.result_valid, bus.err);
      end
      checks++;
      if (bus.img_out !== '0 || bus.byte_count !== 7'd0 || bus.result_out !== 4'd0) begin
         errors++;
         $display("FAIL reset_data got cnt=%0d res=%h img_nonzero=%b want 0 0 0",
                  bus.byte_count, bus.result_out, |bus.img_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load_ff();
      for (int k = 0; k < N_BYTES; k++) img_bytes[k] = 8'hFF;
      for (int k = 0; k < N_LOAD; k++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = (k < N_BYTES) ? 8'hFF : model_sum();
         if (k == N_LOAD - 1) begin
            checks++;
            if (bus.bnn_enable !== 1'b0 || bus.img_buffer_full !== 1'b0) begin
               errors++;
               $display("FAIL ff_early_enable got en=%b full=%b want 0 0",
                        bus.bnn_enable, bus.img_buffer_full);
            end
         end
         @(negedge clk);
      end
      bus.rx_valid = 1'b0;
      checks++;
      if (bus.img_out !== {IMG_BITS{1'b1}}) begin
         errors++;
         $display("FAIL ff_img got %h want all ones", bus.img_out);
      end
      checks++;
      if (bus.bnn_enable !== 1'b1 || bus.img_buffer_full !== 1'b1 || bus.rx_ready !== 1'b0) begin
         errors++;
         $display("FAIL ff_enable got en=%b full=%b rdy=%b want 1 1 0",
                  bus.bnn_enable, bus.img_buffer_full, bus.rx_ready);
      end
   endtask

   task automatic test_result();
      repeat (50) @(negedge clk);
      checks++;
      if (bus.bnn_enable !== 1'b1 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL res_wait got en=%b val=%b want 1 0", bus.bnn_enable, bus.result_valid);
      end
      run_result(4'd7, 0);
      checks++;
      if (bus.result_out !== 4'd7 || bus.result_valid !== 1'b1 || bus.err !== 1'b0 ||
          bus.bnn_enable !== 1'b0 || bus.img_buffer_full !== 1'b0) begin
         errors++;
         $display("FAIL res_capture got res=%0d val=%b err=%b en=%b full=%b want 7 1 0 0 0",
                  bus.result_out, bus.result_valid, bus.err, bus.bnn_enable, bus.img_buffer_full);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b1 || bus.bnn_clear !== 1'b0 || bus.result_out !== 4'd7) begin
         errors++;
         $display("FAIL res_hold got val=%b clr=%b res=%0d want 1 0 7",
                  bus.result_valid, bus.bnn_clear, bus.result_out);
      end
      bus.result_ack = 1'b1;
      @(negedge clk);
      bus.result_ack = 1'b0;
      checks++;
      if (bus.bnn_clear !== 1'b1 || bus.result_valid !== 1'b0 || bus.rx_ready !== 1'b0) begin
         errors++;
         $display("FAIL res_clear got clr=%b val=%b rdy=%b want 1 0 0",
                  bus.bnn_clear, bus.result_valid, bus.rx_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.bnn_clear !== 1'b0 || bus.rx_ready !== 1'b1 || bus.byte_count !== 7'd0 ||
          bus.img_out !== '0 || bus.result_out !== 4'd7 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL res_reload got clr=%b rdy=%b cnt=%0d img_nz=%b res=%0d err=%b want 0 1 0 0 7 0",
                  bus.bnn_clear, bus.rx_ready, bus.byte_count, |bus.img_out, bus.result_out, bus.err);
      end
   endtask

   task automatic test_toggle();
      int count;
      int cyc;
      logic [3:0] r;
      for (int k = 0; k < N_BYTES; k++) img_bytes[k] = 8'(k);
      count = 0;
      cyc   = 0;
      while (count < N_LOAD && cyc < 1000) begin
         checks++;
         if (bus.byte_count !== 7'(count)) begin
            errors++;
            $display("FAIL tog_count got %0d want %0d", bus.byte_count, count);
         end
         bus.rx_valid = (cyc % 2 == 0);
         if (!bus.rx_valid)          bus.rx_data = 8'($urandom);
         else if (count < N_BYTES)   bus.rx_data = img_bytes[count];
         else                        bus.rx_data = model_sum();
         @(negedge clk);
         if (cyc % 2 == 0) count++;
         cyc++;
      end
      bus.rx_valid = 1'b0;
      checks++;
      if (bus.img_out !== model_img()) begin
         errors++;
         $display("FAIL tog_img got %h want %h", bus.img_out, model_img());
      end
      checks++;
      if (bus.img_out[899:896] !== 4'h0 || bus.byte_count !== 7'(N_LOAD) || bus.bnn_enable !== 1'b1) begin
         errors++;
         $display("FAIL tog_tail got top=%h cnt=%0d en=%b want 0 %0d 1",
                  bus.img_out[899:896], bus.byte_count, bus.bnn_enable, N_LOAD);
      end
      r = 4'($urandom_range(10, 0));
      run_result(r, $urandom_range(20, 0));
      checks++;
      if (bus.result_out !== r || bus.result_valid !== 1'b1 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL tog_result got res=%0d val=%b err=%b want %0d 1 0",
                  bus.result_out, bus.result_valid, bus.err, r);
      end
      do_ack($urandom_range(3, 0));
   endtask

   task automatic test_timeout();
      int n;
      rand_bytes();
      load_image(2, 1'b0);
      checks++;
      if (bus.img_out !== model_img()) begin
         errors++;
         $display("FAIL to_img got %h want %h", bus.img_out, model_img());
      end
      n = 0;
      while (bus.result_valid !== 1'b1 && n < 5000) begin
         if (bus.bnn_enable === 1'b1) n++;
         @(negedge clk);
      end
      checks++;
      if (n != 4096) begin
         errors++;
         $display("FAIL to_cycles got %0d want 4096", n);
      end
      checks++;
      if (bus.result_out !== 4'hF || bus.err !== 1'b1 || bus.result_valid !== 1'b1) begin
         errors++;
         $display("FAIL to_result got res=%h err=%b val=%b want f 1 1",
                  bus.result_out, bus.err, bus.result_valid);
      end
      do_ack(1);
      checks++;
      if (bus.err !== 1'b1 || bus.rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL to_retain got err=%b rdy=%b want 1 1", bus.err, bus.rx_ready);
      end
   endtask

   task automatic test_host_clear();
      logic [3:0] r;
      rand_bytes();
      for (int k = 0; k < 60; k++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = img_bytes[k];
         @(negedge clk);
      end
      bus.host_clear = 1'b1;
      bus.rx_data    = 8'($urandom);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      checks++;
      if (bus.bnn_clear !== 1'b1 || bus.rx_ready !== 1'b0 || bus.byte_count !== 7'd60) begin
         errors++;
         $display("FAIL hc_enter got clr=%b rdy=%b cnt=%0d want 1 0 60",
                  bus.bnn_clear, bus.rx_ready, bus.byte_count);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.bnn_clear !== 1'b1) begin
            errors++;
            $display("FAIL hc_hold got clr=%b want 1", bus.bnn_clear);
         end
      end
      bus.host_clear = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.bnn_clear !== 1'b0 || bus.img_out !== '0 || bus.byte_count !== 7'd0 || bus.rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL hc_flush got clr=%b img_nz=%b cnt=%0d rdy=%b want 0 0 0 1",
                  bus.bnn_clear, |bus.img_out, bus.byte_count, bus.rx_ready);
      end
      rand_bytes();
      load_image(1, 1'b0);
      checks++;
      if (bus.img_out !== model_img()) begin
         errors++;
         $display("FAIL hc_fresh got %h want %h", bus.img_out, model_img());
      end
      r = 4'($urandom_range(10, 0));
      run_result(r, $urandom_range(10, 0));
      checks++;
      if (bus.result_out !== r || bus.result_valid !== 1'b1) begin
         errors++;
         $display("FAIL hc_result got res=%0d val=%b want %0d 1", bus.result_out, bus.result_valid, r);
      end
      do_ack(0);
   endtask

   task automatic test_back_to_back();
      logic [3:0] r;
      for (int it = 0; it < 3; it++) begin
         rand_bytes();
         bus.result_ack = 1'b1;
         load_image(it, 1'b0);
         bus.result_ack = 1'b0;
         checks++;
         if (bus.img_out !== model_img() || bus.bnn_enable !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_img it=%0d en=%b val=%b got %h want %h", it, bus.bnn_enable,
                     bus.result_valid, bus.img_out, model_img());
         end
         r = 4'($urandom_range(10, 0));
         run_result(r, $urandom_range(30, 0));
         checks++;
         if (bus.result_out !== r || bus.err !== 1'b0 || bus.result_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result it=%0d got res=%0d err=%b val=%b want %0d 0 1",
                     it, bus.result_out, bus.err, bus.result_valid, r);
         end
         do_ack($urandom_range(3, 0));
         checks++;
         if (bus.byte_count !== 7'd0 || bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rearm got cnt=%0d rdy=%b want 0 1", bus.byte_count, bus.rx_ready);
         end
      end
   endtask

   task automatic test_async_reset();
      rand_bytes();
      for (int k = 0; k < 30; k++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = img_bytes[k];
         @(negedge clk);
      end
      bus.rx_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.byte_count !== 7'd0 || bus.img_out !== '0 || bus.rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL arst got cnt=%0d img_nz=%b rdy=%b want 0 0 1",
                  bus.byte_count, |bus.img_out, bus.rx_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

`ifdef BNN_IMG_CHECKSUM_EN
   task automatic test_checksum_bad();
      int e0;
      rand_bytes();
      e0 = en_cycles;
      load_image(1, 1'b1);
      checks++;
      if (bus.result_valid !== 1'b1 || bus.bnn_enable !== 1'b0 || bus.result_out !== 4'hE ||
          bus.err !== 1'b1 || bus.byte_count !== 7'd114) begin
         errors++;
         $display("FAIL cks_bad got val=%b en=%b res=%h err=%b cnt=%0d want 1 0 e 1 114",
                  bus.result_valid, bus.bnn_enable, bus.result_out, bus.err, bus.byte_count);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (en_cycles != e0) begin
         errors++;
         $display("FAIL cks_enable got %0d enable cycles want 0", en_cycles - e0);
      end
      do_ack(0);
   endtask
`endif

   initial begin
      bus.rx_data         = 8'h00;
      bus.rx_valid        = 1'b0;
      bus.host_clear      = 1'b0;
      bus.result_in       = 4'h0;
      bus.result_ready_in = 1'b0;
      bus.result_ack      = 1'b0;
      test_reset();
      test_load_ff();
      test_result();
      test_toggle();
      test_timeout();
      test_host_clear();
      test_back_to_back();
      test_async_reset();
`ifdef BNN_IMG_CHECKSUM_EN
      test_checksum_bad();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
